// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester handshakes and SRAM bus shared by sram_arbiter and its environment
interface sram_arbiter_if;
    logic       req_a, req_b, we_a, we_b;
    logic [7:0] addr_a, addr_b, wdata_a, wdata_b;
    logic       ack_a, ack_b;
    logic [7:0] rdata_a, rdata_b;
    logic       busy;
    logic       sram_cs, sram_rd, sram_wr;
    logic [7:0] sram_addr, sram_din, sram_dout;
    modport slave (
        input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, sram_dout,
        output ack_a, ack_b, rdata_a, rdata_b, busy, sram_cs, sram_rd, sram_wr, sram_addr, sram_din
    );
    modport master (
        output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, sram_dout,
        input  ack_a, ack_b, rdata_a, rdata_b, busy, sram_cs, sram_rd, sram_wr, sram_addr, sram_din
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: two requesters sharing one asynchronous SRAM through a registered IDLE/SETUP/STROBE/RECOVER sequence
// Optional macro SRAM_ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests; otherwise A has fixed priority.
module sram_arbiter #(
    parameter int unsigned STROBE_CYCLES = 2
) (
    input logic           clk,
    input logic           rst_n,
    sram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;
    localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       win_q, win_d;
    logic       we_q, we_d;
    logic       cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
    logic [7:0] addr_q, addr_d, din_q, din_d;
    logic       ack_a_q, ack_a_d, ack_b_q, ack_b_d;
    logic [7:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic       pick_b;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic       ptr_q, ptr_d;

    // Contention is settled by the pointer; a lone requester always wins.
    always_comb pick_b = (bus.req_a && bus.req_b) ? ptr_q : !bus.req_a;
`else
    // A wins whenever it requests.
    always_comb pick_b = !bus.req_a;
`endif

    // Next state and next registered outputs; strobes default high so they only drop inside STROBE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        we_d      = we_q;
        cs_d      = cs_q;
        rd_d      = 1'b1;
        wr_d      = 1'b1;
        addr_d    = addr_q;
        din_d     = din_q;
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        ptr_d     = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.req_a || bus.req_b) begin
                    state_d = SETUP;
                    cs_d    = 1'b1;
                    win_d   = pick_b;
                    we_d    = pick_b ? bus.we_b : bus.we_a;
                    addr_d  = pick_b ? bus.addr_b : bus.addr_a;
                    din_d   = pick_b ? bus.wdata_b : bus.wdata_a;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                    ptr_d   = !pick_b;
`endif
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = CNT_LOAD;
                rd_d    = we_q;
                wr_d    = !we_q;
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d   = RECOVER;
                    ack_a_d   = !win_q;
                    ack_b_d   = win_q;
                    rdata_a_d = (!we_q && !win_q) ? bus.sram_dout : rdata_a_q;
                    rdata_b_d = (!we_q && win_q) ? bus.sram_dout : rdata_b_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    rd_d  = we_q;
                    wr_d  = !we_q;
                end
            end
            RECOVER: begin
                state_d = IDLE;
                cs_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and every SRAM/requester output come straight from flops; reset aborts any access at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            win_q     <= 1'b0;
            we_q      <= 1'b0;
            cs_q      <= 1'b0;
            rd_q      <= 1'b1;
            wr_q      <= 1'b1;
            addr_q    <= '0;
            din_q     <= '0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            ptr_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_q     <= win_d;
            we_q      <= we_d;
            cs_q      <= cs_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.sram_cs   = cs_q;
    assign bus.sram_rd   = rd_q;
    assign bus.sram_wr   = wr_q;
    assign bus.sram_addr = addr_q;
    assign bus.sram_din  = din_q;
    assign bus.ack_a     = ack_a_q;
    assign bus.ack_b     = ack_b_q;
    assign bus.rdata_a   = rdata_a_q;
    assign bus.rdata_b   = rdata_b_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed table, corner sequences and a randomized transaction-level model for sram_arbiter
module tb_sram_arbiter;
    localparam int S = 2;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_arbiter_if bus2 ();
    sram_arbiter_if bus1 ();
    sram_arbiter_if bus15 ();

    sram_arbiter #(.STROBE_CYCLES(2))  u_dut   (.clk(clk), .rst_n(rst_n), .bus(bus2));
    sram_arbiter #(.STROBE_CYCLES(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    sram_arbiter #(.STROBE_CYCLES(15)) u_dut15 (.clk(clk), .rst_n(rst_n), .bus(bus15));

    // SRAM model: unwritten words read as the inverted address; writes commit on the rising edge of sram_wr.
    logic [7:0] sram_mem [256];
    bit         wr_seen  [256];
    always @(posedge bus2.sram_wr) begin
        if (bus2.sram_cs === 1'b1) begin
            sram_mem[bus2.sram_addr] <= bus2.sram_din;
            wr_seen[bus2.sram_addr]  <= 1'b1;
        end
    end
    assign bus2.sram_dout  = wr_seen[bus2.sram_addr] ? sram_mem[bus2.sram_addr] : ~bus2.sram_addr;
    assign bus1.sram_dout  = bus1.sram_addr ^ 8'h5A;
    assign bus15.sram_dout = bus15.sram_addr ^ 8'h5A;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic mon(input string nm, input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input logic pl, input logic [7:0] pa, input logic [7:0] pd);
        chk({nm, "_strobe_excl"}, {31'd0, rd | wr}, 32'd1);
        if (pl && !(rd && wr)) chk({nm, "_addr_stable"}, {16'd0, a, d}, {16'd0, pa, pd});
    endtask

    // Bus monitor: strobes never low together, address/data frozen while a strobe stays low.
    logic       pl2 = 1'b0, pl1 = 1'b0, pl15 = 1'b0;
    logic [7:0] pa2, pd2, pa1, pd1, pa15, pd15;
    int         wr_low2 = 0, rd_low2 = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            mon("s2", bus2.sram_rd, bus2.sram_wr, bus2.sram_addr, bus2.sram_din, pl2, pa2, pd2);
            mon("s1", bus1.sram_rd, bus1.sram_wr, bus1.sram_addr, bus1.sram_din, pl1, pa1, pd1);
            mon("s15", bus15.sram_rd, bus15.sram_wr, bus15.sram_addr, bus15.sram_din, pl15, pa15, pd15);
            wr_low2 += int'(!bus2.sram_wr);
            rd_low2 += int'(!bus2.sram_rd);
        end
        pl2  = rst_n && !(bus2.sram_rd && bus2.sram_wr);
        pa2  = bus2.sram_addr;
        pd2  = bus2.sram_din;
        pl1  = rst_n && !(bus1.sram_rd && bus1.sram_wr);
        pa1  = bus1.sram_addr;
        pd1  = bus1.sram_din;
        pl15 = rst_n && !(bus15.sram_rd && bus15.sram_wr);
        pa15 = bus15.sram_addr;
        pd15 = bus15.sram_din;
    end

    task automatic drv(input int w, input logic port, input logic rq, input logic we, input logic [7:0] a, input logic [7:0] d);
        case (w)
            2: if (port) begin bus2.req_b = rq; bus2.we_b = we; bus2.addr_b = a; bus2.wdata_b = d; end
               else begin bus2.req_a = rq; bus2.we_a = we; bus2.addr_a = a; bus2.wdata_a = d; end
            1: if (port) begin bus1.req_b = rq; bus1.we_b = we; bus1.addr_b = a; bus1.wdata_b = d; end
               else begin bus1.req_a = rq; bus1.we_a = we; bus1.addr_a = a; bus1.wdata_a = d; end
            default: if (port) begin bus15.req_b = rq; bus15.we_b = we; bus15.addr_b = a; bus15.wdata_b = d; end
               else begin bus15.req_a = rq; bus15.we_a = we; bus15.addr_a = a; bus15.wdata_a = d; end
        endcase
    endtask

    function automatic logic get_ack(input int w, input logic port);
        return w == 2 ? (port ? bus2.ack_b : bus2.ack_a) :
               w == 1 ? (port ? bus1.ack_b : bus1.ack_a) : (port ? bus15.ack_b : bus15.ack_a);
    endfunction

    function automatic logic [7:0] get_rd(input int w, input logic port);
        return w == 2 ? (port ? bus2.rdata_b : bus2.rdata_a) :
               w == 1 ? (port ? bus1.rdata_b : bus1.rdata_a) : (port ? bus15.rdata_b : bus15.rdata_a);
    endfunction

    // One access: request for a single cycle (dropped during SETUP with garbage fields), then wait for ack.
    task automatic op(input int w, input logic port, input logic we, input logic [7:0] a, input logic [7:0] d,
                      output int lat, output logic [7:0] rd, output int extra, output int other);
        drv(w, port, 1'b1, we, a, d);
        @(posedge clk);
        @(negedge clk);
        drv(w, port, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
        lat   = 1;
        other = 0;
        while (!get_ack(w, port) && lat < 40) begin
            other += int'(get_ack(w, !port));
            @(negedge clk);
            lat++;
        end
        if (!get_ack(w, port)) lat = -1;
        rd    = get_rd(w, port);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            extra += int'(get_ack(w, port));
            other += int'(get_ack(w, !port));
        end
    endtask

    task automatic wait_any(output logic who, output logic ok);
        ok  = 1'b0;
        who = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus2.ack_a || bus2.ack_b) begin
                who = bus2.ack_b;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    typedef struct packed {
        logic       port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t       vt [8];
    logic [7:0] ref_mem [256];
    int         lat, extra, other, wl0, rl0, next_s, gp;
    logic [7:0] rd, aa, ab, da, db, ga, gd, grd, era, erb;
    logic       who, ok, ra, rb, wa, wb, gwin, gwe, ptr, ack_e, busy_e;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = ~8'(i);
        for (int w = 0; w < 3; w++) begin
            drv(w == 0 ? 2 : w, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            drv(w == 0 ? 2 : w, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        end
        vt = '{
            '{1'b0, 1'b1, 8'h3C, 8'hA5, 8'h00},
            '{1'b0, 1'b0, 8'h3C, 8'h00, 8'hA5},
            '{1'b1, 1'b1, 8'h00, 8'hFF, 8'h00},
            '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h00},
            '{1'b1, 1'b0, 8'h00, 8'h00, 8'hFF},
            '{1'b0, 1'b0, 8'h10, 8'h00, 8'hEF},
            '{1'b0, 1'b1, 8'h10, 8'h5A, 8'hEF},
            '{1'b0, 1'b0, 8'h10, 8'h00, 8'h5A}
        };

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cs", bus2.sram_cs, 0);
        chk("rst_rd", bus2.sram_rd, 1);
        chk("rst_wr", bus2.sram_wr, 1);
        chk("rst_addr_din", {bus2.sram_addr, bus2.sram_din}, 0);
        chk("rst_ack_busy", {bus2.ack_a, bus2.ack_b, bus2.busy}, 0);
        chk("rst_rdata", {bus2.rdata_a, bus2.rdata_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed single accesses on the STROBE_CYCLES=2 instance
        for (int i = 0; i < 8; i++) begin
            wl0 = wr_low2;
            rl0 = rd_low2;
            op(2, vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, lat, rd, extra, other);
            if (vt[i].we) ref_mem[vt[i].addr] = vt[i].wdata;
            chk($sformatf("vec%0d_latency", i), lat, S + 2);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_single_ack", i), extra, 0);
            chk($sformatf("vec%0d_other_ack", i), other, 0);
            chk($sformatf("vec%0d_wr_low", i), wr_low2 - wl0, vt[i].we ? S : 0);
            chk($sformatf("vec%0d_rd_low", i), rd_low2 - rl0, vt[i].we ? 0 : S);
            chk($sformatf("vec%0d_busy_after", i), bus2.busy, 0);
        end

        // Extreme strobe widths
        op(1, 1'b0, 1'b0, 8'h21, 8'h00, lat, rd, extra, other);
        chk("s1_latency", lat, 3);
        chk("s1_rdata", rd, 8'h7B);
        chk("s1_single_ack", extra, 0);
        op(15, 1'b0, 1'b0, 8'h44, 8'h00, lat, rd, extra, other);
        chk("s15_latency", lat, 17);
        chk("s15_rdata", rd, 8'h1E);
        chk("s15_single_ack", extra, 0);

        // Both requesters hold read requests; pointer restarts at A after reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drv(2, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h00);
        drv(2, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        for (int k = 0; k < 4; k++) begin
            wait_any(who, ok);
            chk($sformatf("contend%0d_ack_seen", k), ok, 1);
            chk($sformatf("contend%0d_winner", k), who, RR_EN ? 1'(k % 2) : 1'b0);
            chk($sformatf("contend%0d_rdata", k), who ? bus2.rdata_b : bus2.rdata_a, who ? 8'hFF : 8'hA5);
        end
        drv(2, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00);
        wait_any(who, ok);
        drv(2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("a_dropped_ack_seen", ok, 1);
        chk("a_dropped_winner", who, 1);
        repeat (6) @(negedge clk);

        // Reset in the middle of a write strobe
        drv(2, 1'b0, 1'b1, 1'b1, 8'h3C, 8'hA5);
        @(posedge clk);
        @(negedge clk);
        drv(2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (bus2.sram_wr === 1'b0) ok = 1'b1;
            else @(negedge clk);
        end
        chk("abort_wr_low_seen", ok, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs", bus2.sram_cs, 0);
        chk("abort_strobes", {bus2.sram_rd, bus2.sram_wr}, 2'b11);
        chk("abort_busy_ack", {bus2.busy, bus2.ack_a, bus2.ack_b}, 0);
        chk("abort_addr_din", {bus2.sram_addr, bus2.sram_din}, 0);
        chk("abort_rdata", {bus2.rdata_a, bus2.rdata_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            extra += int'(bus2.ack_a) + int'(bus2.ack_b) + int'(bus2.busy);
        end
        chk("abort_no_ack", extra, 0);

        // Randomized traffic against a transaction-level model
        next_s = 1;
        gp     = -100;
        era    = 8'h00;
        erb    = 8'h00;
        ptr    = 1'b0;
        gwin   = 1'b0;
        gwe    = 1'b0;
        grd    = 8'h00;
        for (int n = 0; n < 600; n++) begin
            ack_e  = (n == gp + S + 1);
            busy_e = (n >= gp) && (n <= gp + S + 1);
            if (ack_e && !gwe) begin
                if (gwin) erb = grd;
                else era = grd;
            end
            chk("rnd_busy", bus2.busy, busy_e);
            chk("rnd_ack_a", bus2.ack_a, ack_e && !gwin);
            chk("rnd_ack_b", bus2.ack_b, ack_e && gwin);
            chk("rnd_rdata_a", bus2.rdata_a, era);
            chk("rnd_rdata_b", bus2.rdata_b, erb);
            ra = 1'($urandom);
            rb = 1'($urandom);
            wa = 1'($urandom);
            wb = 1'($urandom);
            aa = 8'($urandom_range(0, 15));
            ab = 8'($urandom_range(0, 15));
            da = 8'($urandom);
            db = 8'($urandom);
            drv(2, 1'b0, ra, wa, aa, da);
            drv(2, 1'b1, rb, wb, ab, db);
            if (n + 1 >= next_s && (ra || rb)) begin
                gwin = (ra && rb) ? (RR_EN ? ptr : 1'b0) : rb;
                ptr  = !gwin;
                gwe  = gwin ? wb : wa;
                ga   = gwin ? ab : aa;
                gd   = gwin ? db : da;
                if (gwe) ref_mem[ga] = gd;
                else grd = ref_mem[ga];
                gp     = n + 1;
                next_s = n + 1 + S + 3;
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter: STROBE_CYCLES, 2, cycles rd/wr strobe held low (legal 1..15).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req_a / req_b  input  1  requester A/B access request.
REQ-005 SHALL have ports: we_a / we_b  input  1  1=write, 0=read.
REQ-006 SHALL have ports: addr_a / addr_b  input  8  word address.
REQ-007 SHALL have ports: wdata_a / wdata_b  input  8  write data.
REQ-008 SHALL have ports: ack_a / ack_b  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports: rdata_a / rdata_b  output  8  read data, valid with ack, held until next read for that port.
REQ-010 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have ports: sram_cs  output  1, sram_rd  output  1 (active-low), sram_wr  output  1 (write commits on rising edge), sram_addr  output  8, sram_din  output  8, sram_dout  input  8.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, STROBE, RECOVER; all sram_* outputs registered, glitch-free.
REQ-013 SHALL, in IDLE, drive sram_cs=0, sram_rd=1, sram_wr=1.
REQ-014 SHALL, in IDLE, sample req_a/req_b at clock edge k, select winner, latch its we/addr/wdata, move to SETUP.
REQ-015 SHALL, in SETUP (cycle k+1), drive sram_cs=1, sram_addr/sram_din = latched values, sram_rd=1, sram_wr=1.
REQ-016 SHALL, in STROBE (cycles k+2..k+1+STROBE_CYCLES), drive sram_wr=0 for writes or sram_rd=0 for reads; the other strobe stays 1.
REQ-017 SHALL, for reads, capture sram_dout into the winner's rdata at the edge ending the last STROBE cycle.
REQ-018 SHALL, in RECOVER (cycle k+2+STROBE_CYCLES), drive both strobes 1 with sram_cs=1 and addr/din unchanged, so the sram_wr rising edge commits the write; ack of winner = 1 this cycle only.
REQ-019 SHALL return to IDLE after RECOVER; minimum one IDLE cycle between operations; latency req-sampled to ack = STROBE_CYCLES+2 cycles; throughput one access per STROBE_CYCLES+3 cycles.
REQ-020 SHALL never assert sram_rd=0 and sram_wr=0 simultaneously; sram_addr/sram_din SHALL not change while either strobe is low.
REQ-021 SHALL ignore changes on req/we/addr/wdata after acceptance; a requester dropping req mid-operation still completes and receives ack.
REQ-022 SHALL treat a requester holding req after its ack as a new request, arbitrated in the next IDLE cycle.
REQ-023 SHALL leave the non-winning requester's ack and rdata unchanged.

Reset
REQ-024 SHALL, on rst_n low, immediately force state=IDLE, sram_cs=0, sram_rd=1, sram_wr=1, sram_addr=0, sram_din=0, ack_a=ack_b=0, busy=0, rdata_a=rdata_b=0, priority pointer=A.
REQ-025 SHALL abort any in-flight access on reset without ack; the target word content after an aborted write is undefined.
REQ-026 SHALL resume arbitration on the first clock edge after rst_n deasserts.

Configuration
REQ-027 SHALL support macro SRAM_ARB_ROUND_ROBIN_EN: when defined, simultaneous requests alternate; the pointer toggles to the other port after each granted access, starting at A.
REQ-028 SHALL, without SRAM_ARB_ROUND_ROBIN_EN, give requester A fixed priority on simultaneous requests, with no pointer state.

Verification
REQ-029 SHALL cover: A write addr 0x3C data 0xA5, STROBE_CYCLES=2 -> sram_wr low 2 cycles, ack_a 4 cycles after sampling; a later A read of 0x3C returns rdata_a=0xA5 with ack_a.
REQ-030 SHALL cover: req_a and req_b both held high for reads, with the macro defined -> acks ordered A,B,A,B; without the macro -> A only until req_a drops.
REQ-031 SHALL cover: B write 0xFF to 0x00, then B read of 0xFF -> distinct words; rdata_b=0x00 from preloaded memory, and wrap addressing is not applied.
REQ-032 SHALL cover: rst_n pulsed low during STROBE of a write -> sram_cs=0 and strobes=1 within the same cycle, no ack, busy=0.
REQ-033 SHALL cover: req_a dropped in SETUP -> operation completes, ack_a pulses once, no second access.
REQ-034 SHALL cover: STROBE_CYCLES=1 and 15 -> latency 3 and 17 cycles; a monitor confirms rd/wr never low together and addr stable under strobe.
